// File: rtl/imem_loader.sv
// Framed byte-stream loader for the writable instruction memory: count, big-endian words, XOR checksum.
// Holds the CPU while a session is active and reports done/err status.
module imem_loader #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

    state_t            state, state_d;
    logic [1:0]        byte_idx, byte_idx_d;
    logic [CNT_W-1:0]  word_idx, word_idx_d;
    logic [CNT_W-1:0]  cnt_n, cnt_n_d;
    logic [7:0]        csum, csum_d;
    logic [23:0]       asm_word, asm_word_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
    logic              wr_en_d, done_d, err_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [31:0]       wr_data_d;
    logic [CNT_W-1:0]  words_d;
    logic              accept;

    // Stream-facing status is a pure decode of the state register.
    assign in_ready = (state != IDLE);
    assign cpu_hold = (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_idx     <= '0;
            word_idx     <= '0;
            cnt_n        <= '0;
            csum         <= '0;
            asm_word     <= '0;
            tmo_cnt      <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_d;
            byte_idx     <= byte_idx_d;
            word_idx     <= word_idx_d;
            cnt_n        <= cnt_n_d;
            csum         <= csum_d;
            asm_word     <= asm_word_d;
            tmo_cnt      <= tmo_cnt_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            done         <= done_d;
            err          <= err_d;
            words_loaded <= words_d;
        end
    end

    always_comb begin
        state_d    = state;
        byte_idx_d = byte_idx;
        word_idx_d = word_idx;
        cnt_n_d    = cnt_n;
        csum_d     = csum;
        asm_word_d = asm_word;
        tmo_cnt_d  = tmo_cnt;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        done_d     = 1'b0;
        err_d      = err;
        words_d    = words_loaded;

        if (state == IDLE) begin
            if (start) begin
                state_d    = COUNT;
                err_d      = 1'b0;
                words_d    = '0;
                csum_d     = '0;
                byte_idx_d = '0;
                word_idx_d = '0;
                asm_word_d = '0;
                tmo_cnt_d  = '0;
            end
        end else if (accept) begin
            // An accept always wins over a coincident timeout.
            tmo_cnt_d = '0;
            case (state)
                COUNT: begin
                    csum_d = csum ^ in_data;
                    if (32'(in_data) > DEPTH) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_n_d = CNT_W'(in_data);
                        state_d = (in_data == 8'd0) ? CHECK : DATA;
                    end
                end
                DATA: begin
                    csum_d     = csum ^ in_data;
                    byte_idx_d = byte_idx + 2'd1;
                    asm_word_d = {asm_word[15:0], in_data};
                    if (byte_idx == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_idx[ADDR_W-1:0];
                        wr_data_d  = {asm_word, in_data};
                        word_idx_d = word_idx + CNT_W'(1);
                        words_d    = words_loaded + CNT_W'(1);
                        if (word_idx + CNT_W'(1) == cnt_n) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    done_d  = 1'b1;
                    err_d   = (in_data != csum);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            // Partial word in asm_word is simply dropped.
            tmo_cnt_d = '0;
            err_d     = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
        end else begin
            tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued with the stream and checked at wr_en.
module tb_imem_loader;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned TIMEOUT_CYC = 1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  stim[$];
    logic [36:0] exp_q[$];   // {addr, data}

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: every wr_en must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", wr_addr, wr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             wr_addr, wr_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        int  waited;
        bit  rdy;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            waited++;
        end while (!rdy && waited < 50);
        in_valid = 1'b0;
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready_timeout: got in_ready=0, required 1 within 50 cycles");
        end
    endtask

    // Sends the whole stim queue; optional mid-DATA start pulse after the third byte.
    task automatic run_stream(input int max_gap, input bit mid_start);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], max_gap);
            if (mid_start && i == 2) pulse_start();
        end
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 100) begin @(negedge clk); k++; end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done: got done=0, required 1 within 100 cycles", name);
        end
    endtask

    task automatic build_nominal(input logic [7:0] cs);
        stim = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h07, 8'h00, 8'h03, cs};
        exp_q.push_back({5'd0, 32'h20020005});
        exp_q.push_back({5'd1, 32'h20070003});
    endtask

    task automatic check_end(input string name, input logic exp_err, input int exp_words);
        n_checks++;
        if (err !== exp_err) begin
            n_fail++; $display("FAIL %s_err: got %b, required %b", name, err, exp_err);
        end
        n_checks++;
        if (words_loaded !== (ADDR_W+1)'(exp_words)) begin
            n_fail++; $display("FAIL %s_words: got %0d, required %0d", name, words_loaded, exp_words);
        end
        n_checks++;
        if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_release: got hold=%b ready=%b, required 0 0", name, cpu_hold, in_ready);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL %s_missing_writes: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL %s_done_pulse: got done=%b next cycle, required 0", name, done);
        end
    endtask

    task automatic nominal_session(input string name, input int max_gap, input bit mid_start);
        build_nominal(8'h01);
        pulse_start();
        n_checks++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_start: got hold=%b ready=%b err=%b, required 1 1 0", name, cpu_hold, in_ready, err);
        end
        run_stream(max_gap, mid_start);
        wait_done(name);
        check_end(name, 1'b0, 2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b wr_en=%b addr=%0d data=%08h hold=%b done=%b err=%b words=%0d, required all 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_loaded);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        nominal_session("nominal", 0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        build_nominal(8'hFF);
        pulse_start();
        run_stream(0, 1'b0);
        wait_done("badcs");
        check_end("badcs", 1'b1, 2);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL badcs_sticky: got err=%b, required 1", err);
        end
        pulse_start();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL badcs_clear_on_start: got err=%b, required 0", err);
        end
        stim = '{8'h00, 8'h00};
        run_stream(0, 1'b0);
        wait_done("badcs_followup");
        check_end("badcs_followup", 1'b0, 0);
    endtask

    task automatic test_count_limits();
        logic [7:0]  cs;
        logic [31:0] w;
        stim = '{8'h21};
        pulse_start();
        run_stream(0, 1'b0);
        wait_done("n33");
        check_end("n33", 1'b1, 0);

        stim = '{8'h00, 8'h00};
        pulse_start();
        run_stream(0, 1'b0);
        wait_done("n0");
        check_end("n0", 1'b0, 0);

        stim = '{8'h20};
        cs = 8'h20;
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            exp_q.push_back({5'(i), w});
            for (int j = 3; j >= 0; j--) begin
                stim.push_back(w[j*8 +: 8]);
                cs ^= w[j*8 +: 8];
            end
        end
        stim.push_back(cs);
        pulse_start();
        run_stream(0, 1'b0);
        wait_done("n32");
        check_end("n32", 1'b0, 32);
    endtask

    task automatic test_timeout();
        int n;
        stim = '{8'h01, 8'h20, 8'h02};
        pulse_start();
        run_stream(0, 1'b0);
        n = 0;
        while (!done && n < 2 * TIMEOUT_CYC) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (!done || n != TIMEOUT_CYC) begin
            n_fail++;
            $display("FAIL timeout_latency: got done=%b after %0d cycles, required done=1 after %0d", done, n, TIMEOUT_CYC);
        end
        check_end("timeout", 1'b1, 0);
    endtask

    task automatic test_gaps();
        nominal_session("gaps", 6, 1'b1);
        nominal_session("back_to_back", 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        stim = '{8'h02, 8'h20, 8'h02, 8'h00, 8'h05};
        exp_q.push_back({5'd0, 32'h20020005});
        pulse_start();
        run_stream(0, 1'b0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%b wr_en=%b addr=%0d data=%08h hold=%b done=%b err=%b words=%0d, required all 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err, words_loaded);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL midreset_first_write: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        nominal_session("after_reset", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_count_limits();
        test_timeout();
        test_gaps();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
